encoder_8x3_sync: RTL and testbench
===================================

Name: encoder_8x3_sync

Overview:
- Registered 8-to-3 binary encoder with an enable input.
- Converts an 8-bit request vector into the 3-bit index of the active line, with a valid flag and a multi-hot error flag.
- Sits between one-hot request/select sources and logic that needs a binary index, such as mux selects or arbiter grant indices.
- Fixed priority resolves any non-one-hot input deterministically.

Parameters:
- PRIORITY_MSB, default 1: 1 = highest set bit index wins; 0 = lowest set bit index wins.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- en  input  1  encode enable; when low, outputs are forced to idle on the next edge
- in  input  8  request vector; bit i requests index i
- y  output  3  encoded index of the selected bit (registered)
- valid  output  1  1 when y holds a real encode (registered)
- multi_hot  output  1  1 when more than one bit of in was set in the encoded sample (registered)

Behaviour:
- Clocking and reset:
  - Single clock domain; every output is a flop.
  - Reset is synchronous and active-low: on a rising clk with rst_n=0, y=3'b000, valid=0, multi_hot=0.
  - Reset overrides en and in.
  - Reset asserted mid-stream clears the outputs on that edge; no state survives reset.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Rising edge with rst_n=1, en=0: y=0, valid=0, multi_hot=0. Enable low always reads as idle; no output is held.
- Rising edge with rst_n=1, en=1, in=0: y=0, valid=0, multi_hot=0. No request means no valid encode; y=0 is not index 0 unless valid=1.
- Rising edge with rst_n=1, en=1, in one-hot at bit k: y=k, valid=1, multi_hot=0. Map: 01->0, 02->1, 04->2, 08->3, 10->4, 20->5, 40->6, 80->7.
- Rising edge with rst_n=1, en=1, in with two or more bits set:
  - valid=1, multi_hot=1.
  - PRIORITY_MSB=1: y = index of the highest set bit.
  - PRIORITY_MSB=0: y = index of the lowest set bit.
- Outputs are steady between edges; no combinational path from inputs to outputs.
- Back-to-back changes of in on consecutive cycles each produce a result; no throughput bubbles.

Decomposition:
- Shared package enc_pkg:
  - IN_W=8, OUT_W=3
  - localparam IDX_NONE = 3'b000
  - an encode-result typedef struct {logic [2:0] idx; logic valid; logic multi_hot;}
- One natural sub-module: enc_8x3_comb. It is the purely combinational priority encode plus popcount>1 detect, parameterised by PRIORITY_MSB.
- The top wraps enc_8x3_comb with the en gating and the synchronous-reset output register.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with en=1, in=8'hFF. Required: y=0, valid=0, multi_hot=0. After release with in=8'h00, outputs stay 0.
- Disabled then walk: en=0, in=8'h00 for 1 cycle, then en=1, then in=01,02,04,08,10,20,40,80 on consecutive cycles. Required: one cycle later each, y=0..7 with valid=1 and multi_hot=0. While en=0: valid=0.
- Enable gating: en=1, in=8'h20, then en drops to 0 with in unchanged. Required: y=5, valid=1 first; next cycle y=0, valid=0.
- Multi-hot priority: en=1, in=8'b1000_0101. Required with PRIORITY_MSB=1: y=7, valid=1, multi_hot=1. Required with PRIORITY_MSB=0: y=0, valid=1, multi_hot=1.
- Zero input while enabled: en=1, in=8'h00. Required: y=0, valid=0, multi_hot=0, distinguishing it from in=8'h01 (y=0, valid=1).
- Mid-stream reset: walking pattern running; assert rst_n=0 for exactly one edge while in=8'h40. Required: outputs 0 on that edge, then resume with y=6, valid=1 on the following edge.

Source files
------------

// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the registered 8-to-3 encoder:
//   IN_W / OUT_W  : request vector width and encoded index width
//   IDX_NONE      : index value presented whenever no valid encode exists
//   enc_res_t     : one encode result (index, valid, multi-hot flag)
//   is_multi_hot  : 1 when two or more bits of a request vector are set
// -----------------------------------------------------------------------------
package enc_pkg;

   localparam int IN_W  = 8;
   localparam int OUT_W = 3;

   localparam logic [OUT_W-1:0] IDX_NONE = 3'b000;
   localparam logic [IN_W-1:0]  IN_ONE   = 8'h01;

   typedef struct packed {
      logic [OUT_W-1:0] idx;
      logic             valid;
      logic             multi_hot;
   } enc_res_t;

   localparam enc_res_t RES_IDLE = '{idx: IDX_NONE, valid: 1'b0, multi_hot: 1'b0};

   // Clearing the lowest set bit leaves something behind only when more than
   // one bit was set, so this avoids a full popcount.
   function automatic logic is_multi_hot(input logic [IN_W-1:0] v);
      return (v & (v - IN_ONE)) != '0;
   endfunction

endpackage

// File: rtl/enc_8x3_comb.sv
// -----------------------------------------------------------------------------
// enc_8x3_comb
// Purely combinational fixed-priority 8-to-3 encode with multi-hot detect.
// Parameters:
//   PRIORITY_MSB : 1 = highest set bit wins, 0 = lowest set bit wins
// Ports:
//   i_req : request vector, bit i requests index i
//   o_res : encode result; idx = IDX_NONE and valid = 0 when i_req is zero
// -----------------------------------------------------------------------------
module enc_8x3_comb
   import enc_pkg::*;
#(
   parameter int PRIORITY_MSB = 1
) (
   input  logic [IN_W-1:0] i_req,
   output enc_res_t        o_res
);

   always_comb begin
      o_res           = RES_IDLE;
      o_res.valid     = |i_req;
      o_res.multi_hot = is_multi_hot(i_req);
      // The last match in scan order wins, so the scan runs towards the
      // bit that should have priority.
      if (PRIORITY_MSB != 0) begin
         for (int i = 0; i < IN_W; i++) begin
            if (i_req[i]) o_res.idx = i[OUT_W-1:0];
         end
      end else begin
         for (int i = IN_W - 1; i >= 0; i--) begin
            if (i_req[i]) o_res.idx = i[OUT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/encoder_8x3_sync.sv
// -----------------------------------------------------------------------------
// encoder_8x3_sync
// Registered 8-to-3 binary encoder with enable. One cycle of latency, every
// output is a flop, no combinational input-to-output path.
// Parameters:
//   PRIORITY_MSB : 1 = highest set bit wins, 0 = lowest set bit wins
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset, overrides en and in
//   en        : encode enable; low forces idle outputs on the next edge
//   in        : request vector, bit i requests index i
//   y         : encoded index (IDX_NONE unless valid)
//   valid     : y holds a real encode
//   multi_hot : more than one request bit was set in the encoded sample
// -----------------------------------------------------------------------------
module encoder_8x3_sync
   import enc_pkg::*;
#(
   parameter int PRIORITY_MSB = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [IN_W-1:0]  in,
   output logic [OUT_W-1:0] y,
   output logic             valid,
   output logic             multi_hot
);

   enc_res_t w_res_p0;
   enc_res_t r_res_p1;

   enc_8x3_comb #(
      .PRIORITY_MSB(PRIORITY_MSB)
   ) u_comb (
      .i_req(in),
      .o_res(w_res_p0)
   );

   // p0 -> p1: enable gating and output register. Disable reads as idle
   // rather than holding the previous result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_res_p1 <= RES_IDLE;
      end else if (!en) begin
         r_res_p1 <= RES_IDLE;
      end else begin
         r_res_p1 <= w_res_p0;
      end
   end

   assign y         = r_res_p1.idx;
   assign valid     = r_res_p1.valid;
   assign multi_hot = r_res_p1.multi_hot;

endmodule

// File: tb/tb_encoder_8x3_sync.sv
// -----------------------------------------------------------------------------
// tb_encoder_8x3_sync
// Directed bench for encoder_8x3_sync. Two instances share the stimulus:
// u_msb (PRIORITY_MSB=1) and u_lsb (PRIORITY_MSB=0).
// -----------------------------------------------------------------------------
module tb_encoder_8x3_sync;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] in_v;
   logic [2:0] y_msb, y_lsb;
   logic       valid_msb, valid_lsb;
   logic       mh_msb, mh_lsb;

   int n_cmp;
   int n_bad;

   encoder_8x3_sync #(.PRIORITY_MSB(1)) u_msb (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in_v),
      .y(y_msb), .valid(valid_msb), .multi_hot(mh_msb)
   );

   encoder_8x3_sync #(.PRIORITY_MSB(0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in_v),
      .y(y_lsb), .valid(valid_lsb), .multi_hot(mh_lsb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   // Apply inputs away from the active edge, then sample #1 after it.
   task automatic cyc(input logic r, input logic e, input logic [7:0] v);
      @(negedge clk);
      rst_n = r;
      en    = e;
      in_v  = v;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [2:0] ey_msb,
                             input logic [2:0] ey_lsb, input logic ev, input logic emh);
      chk({tag, ".y_msb"},     {5'd0, y_msb},     {5'd0, ey_msb});
      chk({tag, ".y_lsb"},     {5'd0, y_lsb},     {5'd0, ey_lsb});
      chk({tag, ".valid_msb"}, {7'd0, valid_msb}, {7'd0, ev});
      chk({tag, ".valid_lsb"}, {7'd0, valid_lsb}, {7'd0, ev});
      chk({tag, ".mh_msb"},    {7'd0, mh_msb},    {7'd0, emh});
      chk({tag, ".mh_lsb"},    {7'd0, mh_lsb},    {7'd0, emh});
   endtask

   logic [7:0] walk_in [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      en    = 1'b1;
      in_v  = 8'hFF;

      // Reset held two edges with everything asserted
      cyc(1'b0, 1'b1, 8'hFF);
      expect_out("rst0", 3'd0, 3'd0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'hFF);
      expect_out("rst1", 3'd0, 3'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 8'h00);
      expect_out("rel", 3'd0, 3'd0, 1'b0, 1'b0);

      // Disabled, then walking one-hot
      cyc(1'b1, 1'b0, 8'h00);
      expect_out("dis", 3'd0, 3'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'h80);
      expect_out("dis_req", 3'd0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b1, walk_in[k]);
         expect_out($sformatf("walk%0d", k), k[2:0], k[2:0], 1'b1, 1'b0);
      end

      // Enable gating: no hold when en drops
      cyc(1'b1, 1'b1, 8'h20);
      expect_out("gate_on", 3'd5, 3'd5, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'h20);
      expect_out("gate_off", 3'd0, 3'd0, 1'b0, 1'b0);

      // Multi-hot priority
      cyc(1'b1, 1'b1, 8'b1000_0101);
      expect_out("mh85", 3'd7, 3'd0, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 8'hFF);
      expect_out("mhFF", 3'd7, 3'd0, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 8'h18);
      expect_out("mh18", 3'd4, 3'd3, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 8'h06);
      expect_out("mh06", 3'd2, 3'd1, 1'b1, 1'b1);

      // Zero input versus index 0
      cyc(1'b1, 1'b1, 8'h00);
      expect_out("zero", 3'd0, 3'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 8'h01);
      expect_out("one", 3'd0, 3'd0, 1'b1, 1'b0);

      // Mid-stream single-edge reset
      cyc(1'b1, 1'b1, 8'h10);
      expect_out("ms10", 3'd4, 3'd4, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 8'h20);
      expect_out("ms20", 3'd5, 3'd5, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 8'h40);
      expect_out("ms_rst", 3'd0, 3'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 8'h40);
      expect_out("ms40", 3'd6, 3'd6, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 8'h80);
      expect_out("ms80", 3'd7, 3'd7, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
